// File: rtl/mul_div_unit.sv
// Multiply/divide unit with HI/LO registers and fixed multi-cycle latency.
// Define MDU_MADD_EN to enable madd/msub (ops 110/111); otherwise they are no-ops.
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] res;
    logic        res_we;

    logic [63:0] prod_s, prod_u;
    logic [31:0] q_s, r_s, q_u, r_u;
    logic        b_zero, div_ovf;

    // Results are formed at acceptance and held; only the HI/LO write is delayed.
    always_comb begin
        prod_s  = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        prod_u  = {32'd0, a} * {32'd0, b};
        b_zero  = (b == 32'd0);
        div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        q_s     = 32'd0;
        r_s     = 32'd0;
        q_u     = 32'd0;
        r_u     = 32'd0;
        if (!b_zero) begin
            q_u = a / b;
            r_u = a % b;
            if (div_ovf) begin
                q_s = 32'h8000_0000;
                r_s = 32'd0;
            end else begin
                q_s = 32'($signed(a) / $signed(b));
                r_s = 32'($signed(a) % $signed(b));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            busy   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            res    <= 64'd0;
            res_we <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                res    <= (op == OP_MULT) ? prod_s : prod_u;
                                res_we <= 1'b1;
                                cnt    <= 4'(MUL_CYCLES);
                                busy   <= 1'b1;
                                state  <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                res    <= (op == OP_DIV) ? {r_s, q_s} : {r_u, q_u};
                                res_we <= !b_zero;
                                cnt    <= 4'(DIV_CYCLES);
                                busy   <= 1'b1;
                                state  <= DIV;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
`ifdef MDU_MADD_EN
                            OP_MADD, OP_MSUB: begin
                                res    <= (op == OP_MADD) ? ({hi, lo} + prod_s)
                                                          : ({hi, lo} - prod_s);
                                res_we <= 1'b1;
                                cnt    <= 4'(MUL_CYCLES);
                                busy   <= 1'b1;
                                state  <= MUL;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (cnt == 4'd1) begin
                        if (res_we) begin
                            hi <= res[63:32];
                            lo <= res[31:0];
                        end
                        cnt   <= 4'd0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO queued at issue, checked at completion.
module tb_mul_div_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    mul_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference via sign/magnitude so it is independent of the RTL formulation.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] h,
                                          input logic [31:0] l);
        logic [31:0] ux, uy, q, r;
        logic [63:0] p;
        ux = x[31] ? -x : x;
        uy = y[31] ? -y : y;
        p  = {32'd0, ux} * {32'd0, uy};
        if (x[31] ^ y[31]) p = -p;
        case (o)
            3'b000: return p;
            3'b001: return {32'd0, x} * {32'd0, y};
            3'b010: begin
                if (y == 0) return {h, l};
                q = ux / uy; r = ux % uy;
                if (x[31] ^ y[31]) q = -q;
                if (x[31]) r = -r;
                return {r, q};
            end
            3'b011: return (y == 0) ? {h, l} : {x % y, x / y};
`ifdef MDU_MADD_EN
            3'b110: return {h, l} + p;
            3'b111: return {h, l} - p;
`endif
            default: return {h, l};
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] e;
        e = model(o, x, y, m_hi, m_lo);
        if (o inside {3'b000, 3'b001, 3'b010, 3'b011}) sb_q.push_back(e);
`ifdef MDU_MADD_EN
        if (o inside {3'b110, 3'b111}) sb_q.push_back(e);
`endif
        start = 1'b1; op = o; a = x; b = y;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_n, input bit inject);
        int n;
        logic [63:0] e;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (inject && n == 1) begin
                start = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            cyc();
        end
        start = 1'b0;
        vectors++;
        if (n !== exp_n) begin
            miscompares++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, n, exp_n);
        end
        e = (sb_q.size() != 0) ? sb_q.pop_front() : {m_hi, m_lo};
        m_hi = e[63:32]; m_lo = e[31:0];
        vectors++;
        if (hi !== m_hi || lo !== m_lo) begin
            miscompares++;
            $display("FAIL %s hilo got %h_%h want %h_%h", name, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic move(input string name, input logic [2:0] o, input logic [31:0] x);
        issue(o, x, 32'd0);
        if (o == 3'b100) m_hi = x; else m_lo = x;
        vectors++;
        if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0",
                     name, hi, lo, busy, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cyc(); cyc();
        resetn = 1'b1;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
    endtask

    task automatic test_mult();
        issue(3'b000, 32'hFFFF_FFFE, 32'd3);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mult_busy_rise got %b want 1", busy);
        end
        wait_done("mult", MUL_N, 1'b0);
    endtask

    task automatic test_back_to_back();
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu", MUL_N, 1'b0);
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept got busy=%b want 1", busy);
        end
        wait_done("div_neg", DIV_N, 1'b0);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", DIV_N, 1'b0);
        issue(3'b011, 32'd1000, 32'd7);
        wait_done("divu", DIV_N, 1'b0);
    endtask

    task automatic test_div_zero();
        move("mthi_11", 3'b100, 32'h11);
        move("mtlo_22", 3'b101, 32'h22);
        issue(3'b011, 32'd5, 32'd0);
        wait_done("divu_zero", DIV_N, 1'b0);
        issue(3'b010, 32'hFFFF_0000, 32'd0);
        wait_done("div_zero", DIV_N, 1'b0);
        move("mthi_abcd", 3'b100, 32'hABCD);
    endtask

    task automatic test_cancel_and_ignore();
        cancel = 1'b1;
        start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
        cyc();
        start = 1'b0; cancel = 1'b0;
        vectors++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            miscompares++;
            $display("FAIL cancel got busy=%b hi=%h lo=%h want 0/%h/%h", busy, hi, lo, m_hi, m_lo);
        end
        issue(3'b000, 32'd7, 32'd6);
        wait_done("ignore_during_busy", MUL_N, 1'b1);
    endtask

    task automatic test_reset_mid();
        issue(3'b010, 32'd100, 32'd3);
        cyc(); cyc();
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        sb_q.delete();
        m_hi = 32'd0; m_lo = 32'd0;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
    endtask

    task automatic test_madd();
        move("madd_hi0", 3'b100, 32'd0);
        move("madd_loF", 3'b101, 32'hFFFF_FFFF);
        issue(3'b110, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        wait_done("madd", MUL_N, 1'b0);
        issue(3'b111, 32'd3, 32'hFFFF_FFFE);
        wait_done("msub", MUL_N, 1'b0);
`else
        wait_done("madd_noop", 0, 1'b0);
        issue(3'b111, 32'd3, 32'd4);
        wait_done("msub_noop", 0, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_div_zero();
        test_cancel_and_ignore();
        test_reset_mid();
        test_madd();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
